// File: rtl/apb_timer_sequencer.sv
// APB master that programs a down-counter slave (MAX, LOAD, ENABLE), polls CUR until zero, then disables it.
// Optional macro SEQ_TIMEOUT_EN bounds the number of CUR polls to MAX_POLLS.
module apb_timer_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int POLL_GAP   = 4,
  parameter int MAX_POLLS  = 1024
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] cur_val,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, FIN} state_t;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} step_t;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_t                r_state;
  step_t                 r_step;
  logic [GAP_W-1:0]      r_gap;
  logic                  r_abort_pend;
  logic                  w_launch;
  step_t                 w_next_step;
  logic                  w_timeout;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Decide whether a new SETUP phase starts next cycle and for which step.
  always_comb begin
    w_launch    = 1'b0;
    w_next_step = r_step;
    case (r_state)
      IDLE: if (start) begin
        w_launch    = 1'b1;
        w_next_step = S0;
      end
      ACCESS: if (PREADY && r_step != S4) begin
        if (PSLVERR || abort || r_abort_pend ||
            (r_step == S3 && (PRDATA == '0 || w_timeout))) begin
          w_launch    = 1'b1;
          w_next_step = S4;
        end else if (r_step != S3) begin
          w_launch    = 1'b1;
          w_next_step = step_t'(r_step + 3'd1);
        end
      end
      GAP: if (abort) begin
        w_launch    = 1'b1;
        w_next_step = S4;
      end else if (r_gap == GAP_LAST) begin
        w_launch    = 1'b1;
        w_next_step = S3;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    case (w_next_step)
      S0: begin
        w_addr  = ADDR_WIDTH'(4);
        w_wdata = load_val;
      end
      S1: w_wdata = DATA_WIDTH'(2);
      S2: w_wdata = DATA_WIDTH'(1);
      S3: w_addr  = ADDR_WIDTH'(8);
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state      <= IDLE;
      r_step       <= S0;
      r_gap        <= '0;
      r_abort_pend <= 1'b0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cur_val      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          busy <= 1'b1;
          err  <= 1'b0;
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: if (PREADY) begin
          if (r_step == S3) cur_val <= PRDATA;
          if (PSLVERR || (r_step == S3 && w_timeout && PRDATA != '0)) err <= 1'b1;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (r_step == S4) begin
            r_state <= FIN;
            done    <= 1'b1;
          end else begin
            r_state <= GAP;
            r_gap   <= '0;
          end
        end
        GAP: r_gap <= r_gap + GAP_W'(1);
        FIN: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A launch overrides the idle/gap defaults chosen above.
      if (w_launch) begin
        r_state <= SETUP;
        r_step  <= w_next_step;
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PWRITE  <= (w_next_step != S3);
        PADDR   <= w_addr;
        PWDATA  <= w_wdata;
      end
      if ((w_launch && w_next_step == S4) || r_state == FIN)
        r_abort_pend <= 1'b0;
      else if (abort && (r_state == SETUP || r_state == ACCESS))
        r_abort_pend <= 1'b1;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  logic [POLL_W-1:0] r_polls;

  // True while the CUR read in flight is the MAX_POLLS-th one.
  assign w_timeout = (r_polls == POLL_W'(MAX_POLLS - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET)
      r_polls <= '0;
    else if (r_state == IDLE && start)
      r_polls <= '0;
    else if (r_state == ACCESS && PREADY && r_step == S3)
      r_polls <= r_polls + POLL_W'(1);
  end
`else
  assign w_timeout = (MAX_POLLS < 0);
`endif

endmodule

// File: tb/tb_apb_timer_sequencer.sv
// Self-checking bench for apb_timer_sequencer: behavioural down-counter slave, transfer log, expected-transfer model.
module tb_apb_timer_sequencer;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int PG = 3;
  localparam int MP = 4;

  logic          PCLK = 1'b0;
  logic          PRESET, start, abort;
  logic [DW-1:0] load_val;
  logic          busy, done, err;
  logic [DW-1:0] cur_val;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA  = '0;
  logic          PREADY  = 1'b0;
  logic          PSLVERR = 1'b0;

  apb_timer_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_GAP(PG), .MAX_POLLS(MP)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .load_val(load_val), .abort(abort),
    .busy(busy), .done(done), .err(err), .cur_val(cur_val),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            ncyc;
  } xfer_t;

  xfer_t log_q[$];
  xfer_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] s_max = '0, s_cur = '0;
  logic          s_en = 1'b0;
  bit            s_stuck = 1'b0;
  int wait_first = 0, wait_rest = 0, err_idx = -1;
  int xfer_idx = 0, acc = 0, cur_wait = 0;
  int n_unstable = 0, n_gap_bad = 0, n_done = 0, n_idle = 0;
  bit prev_read = 1'b0;
  logic [AW-1:0] su_addr;
  logic          su_wr;
  logic [DW-1:0] su_wdata;
  logic [DW-1:0] model_cur = '0;

  // Slave: MAX/CTRL registers, CUR returns its value then counts down while enabled.
  always @(negedge PCLK) begin
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    if (done) n_done++;
    if (PENABLE && !PSEL) n_unstable++;
    if (PSEL && !busy) n_unstable++;
    if (PSEL && !PENABLE) begin
      if (prev_read && !PWRITE && PADDR == AW'(8) && n_idle != PG) n_gap_bad++;
      n_idle = 0; acc = 0;
      cur_wait = (xfer_idx == 0) ? wait_first : wait_rest;
      if (cur_wait < 0) cur_wait = $urandom_range(0, 2);
      su_addr = PADDR; su_wr = PWRITE; su_wdata = PWDATA;
    end else if (PSEL && PENABLE) begin
      if (PADDR !== su_addr || PWRITE !== su_wr || PWDATA !== su_wdata) n_unstable++;
      acc++;
      if (acc > cur_wait) begin
        PREADY  = 1'b1;
        PSLVERR = (xfer_idx == err_idx);
        if (PWRITE) begin
          if (PADDR == AW'(4)) s_max = PWDATA;
          else if (PADDR == AW'(0)) begin
            s_en = PWDATA[0];
            if (PWDATA[1]) s_cur = s_max;
          end
        end else begin
          PRDATA = s_cur;
          if (s_en && s_cur != '0 && !s_stuck) s_cur = s_cur - 1;
        end
        log_q.push_back('{PWRITE, PADDR, PWRITE ? PWDATA : PRDATA, acc});
        prev_read = !PWRITE;
        xfer_idx++;
      end
    end else if (busy) n_idle++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected transfer list: three setup writes, CUR reads counting down to zero, final CTRL=0.
  function automatic bit build_exp(input logic [DW-1:0] L, input bit stuck, input int eidx);
    logic [DW-1:0] v = L;
    int nreads = 0, limit = 0;
    bit tout = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    limit = MP;
`endif
    exp_q.delete();
    exp_q.push_back('{1'b1, AW'(4), L, 0});
    exp_q.push_back('{1'b1, AW'(0), DW'(2), 0});
    exp_q.push_back('{1'b1, AW'(0), DW'(1), 0});
    while (nreads < 1000) begin
      exp_q.push_back('{1'b0, AW'(8), v, 0});
      nreads++;
      if (v == '0) break;
      if (limit > 0 && nreads == limit) begin tout = 1'b1; break; end
      if (!stuck) v = v - 1;
    end
    exp_q.push_back('{1'b1, AW'(0), DW'(0), 0});
    if (eidx >= 0 && eidx < exp_q.size() - 1) begin
      while (exp_q.size() > eidx + 1) void'(exp_q.pop_back());
      exp_q.push_back('{1'b1, AW'(0), DW'(0), 0});
      return 1'b1;
    end
    return tout || (eidx == exp_q.size() - 1);
  endfunction

  task automatic clear_mon();
    log_q.delete();
    xfer_idx = 0; n_done = 0; n_unstable = 0; n_gap_bad = 0; prev_read = 1'b0; n_idle = 0;
  endtask

  task automatic start_seq(input logic [DW-1:0] L);
    clear_mon();
    load_val = L; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (busy !== 1'b0 && cyc < 3000) begin @(negedge PCLK); cyc++; end
    chk({tag, " terminates"}, 64'(cyc < 3000), 64'(1));
    @(negedge PCLK);
  endtask

  task automatic check_seq(input string tag, input bit exp_err);
    int n;
    chk({tag, " xfer count"}, 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s xfer%0d", tag, i),
          64'({log_q[i].wr, log_q[i].addr, log_q[i].data}),
          64'({exp_q[i].wr, exp_q[i].addr, exp_q[i].data}));
      if (!exp_q[i].wr) model_cur = exp_q[i].data;
    end
    chk({tag, " done pulses"}, 64'(n_done), 64'(1));
    chk({tag, " err"}, 64'(err), 64'(exp_err));
    chk({tag, " cur_val"}, 64'(cur_val), 64'(model_cur));
    chk({tag, " protocol"}, 64'(n_unstable), 64'(0));
    chk({tag, " gap len"}, 64'(n_gap_bad), 64'(0));
    chk({tag, " busy low"}, 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, " bus"}, 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'(0));
    chk({tag, " status"}, 64'({busy, done, err}), 64'(0));
    chk({tag, " cur_val"}, 64'(cur_val), 64'(0));
  endtask

  initial begin
    bit e;
    int cyc;
    logic [DW-1:0] L;
    PRESET = 1'b1; start = 1'b0; abort = 1'b0; load_val = '0;
    repeat (3) @(negedge PCLK);
    check_reset_outs("reset");
    PRESET = 1'b0;
    @(negedge PCLK);

    // Abort while idle does nothing
    abort = 1'b1; @(negedge PCLK); abort = 1'b0; @(negedge PCLK);
    chk("idle abort busy", 64'({busy, PSEL, done}), 64'(0));

    // Basic run from 3, zero wait states
    e = build_exp(3, 1'b0, -1);
    start_seq(3);
    chk("first cycle", 64'({busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA}),
        64'({1'b1, 1'b1, 1'b0, 1'b1, AW'(4), DW'(3)}));
    wait_idle("basic");
    check_seq("basic", e);

    // Wait states on the first write only
    wait_first = 3; wait_rest = 0;
    e = build_exp(1, 1'b0, -1);
    start_seq(1);
    wait_idle("wait");
    check_seq("wait", e);
    chk("wait access cycles", 64'(log_q.size() > 0 ? log_q[0].ncyc : -1), 64'(4));
    wait_first = 0;

    // Slave error on the CTRL=2 write, then err clears on next start
    err_idx = 1;
    e = build_exp(3, 1'b0, 1);
    start_seq(3);
    wait_idle("slverr");
    check_seq("slverr", e);
    err_idx = -1;
    e = build_exp(0, 1'b0, -1);
    start_seq(0);
    chk("err cleared on start", 64'(err), 64'(0));
    wait_idle("zero");
    check_seq("zero", e);

    // Abort during a poll gap after two CUR reads
    start_seq(100);
    cyc = 0;
    while (!(xfer_idx >= 5 && busy && !PSEL) && cyc < 500) begin @(negedge PCLK); cyc++; end
    chk("abort reach gap", 64'(cyc < 500), 64'(1));
    abort = 1'b1; @(negedge PCLK); abort = 1'b0;
    wait_idle("abort");
    exp_q.delete();
    exp_q.push_back('{1'b1, AW'(4), DW'(100), 0});
    exp_q.push_back('{1'b1, AW'(0), DW'(2), 0});
    exp_q.push_back('{1'b1, AW'(0), DW'(1), 0});
    exp_q.push_back('{1'b0, AW'(8), DW'(100), 0});
    exp_q.push_back('{1'b0, AW'(8), DW'(99), 0});
    exp_q.push_back('{1'b1, AW'(0), DW'(0), 0});
    check_seq("abort", 1'b0);

    // Reset in the middle of the CTRL=1 access
    wait_first = 3; wait_rest = 3;
    start_seq(2);
    cyc = 0;
    while (!(PSEL && PENABLE && PADDR == AW'(0) && PWDATA == DW'(1)) && cyc < 500) begin
      @(negedge PCLK); cyc++;
    end
    chk("reach S2 access", 64'(cyc < 500), 64'(1));
    PRESET = 1'b1; @(negedge PCLK);
    check_reset_outs("midreset");
    chk("midreset no done", 64'(n_done), 64'(0));
    PRESET = 1'b0; wait_first = 0; wait_rest = 0; model_cur = '0;
    @(negedge PCLK);
    e = build_exp(2, 1'b0, -1);
    start_seq(2);
    wait_idle("after reset");
    check_seq("after reset", e);

`ifdef SEQ_TIMEOUT_EN
    // CUR stuck nonzero: poll limit trips
    s_stuck = 1'b1;
    e = build_exp(5, 1'b1, -1);
    start_seq(5);
    wait_idle("timeout");
    check_seq("timeout", e);
    s_stuck = 1'b0;
`endif

    // Randomized runs: load value, wait states and slave error position
    wait_first = -1; wait_rest = -1;
    for (int k = 0; k < 8; k++) begin
      L = DW'($urandom_range(0, 6));
      err_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      e = build_exp(L, 1'b0, err_idx);
      start_seq(L);
      wait_idle($sformatf("rand%0d", k));
      check_seq($sformatf("rand%0d", k), e);
    end
    err_idx = -1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_timer_sequencer.md
APB_TIMER_SEQUENCER -- requirements
Module: apb_timer_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, as the APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, as the APB data and count width.
REQ-003 The block SHALL have parameter POLL_GAP, default 4, as the idle cycles between consecutive CUR reads (minimum 1).
REQ-004 The block SHALL have parameter MAX_POLLS, default 1024, as the CUR read limit (used only under SEQ_TIMEOUT_EN).
REQ-005 The block SHALL have port PCLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port PRESET, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle request to run a countdown.
REQ-008 The block SHALL have port load_val, input, DATA_WIDTH bits: countdown start value, sampled with start.
REQ-009 The block SHALL have port abort, input, 1 bit: request early stop of a running sequence.
REQ-010 The block SHALL have port busy, output, 1 bit: high from accepted start until the done cycle inclusive.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when the sequence ends.
REQ-012 The block SHALL have port err, output, 1 bit: sticky error flag.
REQ-013 The block SHALL have port cur_val, output, DATA_WIDTH bits: last CUR value read.
REQ-014 The block SHALL have APB master outputs PSEL, PENABLE, PWRITE (1 bit each), PADDR (ADDR_WIDTH) and PWDATA (DATA_WIDTH).
REQ-015 The block SHALL have APB master inputs PRDATA (DATA_WIDTH), PREADY (1) and PSLVERR (1), driven by the down-counter slave.

Function
REQ-016 Slave map SHALL be CTRL=0x0 (bit0 ENABLE, bit1 LOAD), MAX=0x4, CUR=0x8 (read-only).
REQ-017 Each transfer SHALL be one SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS cycles (PSEL=1, PENABLE=1) until PREADY=1; PADDR/PWRITE/PWDATA stable throughout.
REQ-018 Sequence steps SHALL be: S0 write MAX=load_val; S1 write CTRL=0x2; S2 write CTRL=0x1; S3 read CUR (repeated); S4 write CTRL=0x0.
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS, GAP, FIN; a step register selects S0-S4.
REQ-020 start SHALL be accepted only in IDLE; start sampled high at edge N gives busy=1 and S0 SETUP from cycle N+1; start while busy is ignored.
REQ-021 Write steps S0-S2 SHALL proceed back-to-back: next SETUP in the cycle after the completing ACCESS.
REQ-022 On S3 completion cur_val SHALL load PRDATA; PRDATA==0 advances to S4, otherwise GAP for POLL_GAP cycles (PSEL=0) then S3 again.
REQ-023 On S4 completion the FSM SHALL enter FIN for one cycle with done=1, then IDLE with busy=0.
REQ-024 PSLVERR=1 on any completing transfer SHALL set err and jump to S4; PSLVERR on S4 itself goes to FIN directly.
REQ-025 abort SHALL never cut a transfer: taken at the next transfer completion or in GAP, next step becomes S4; abort in IDLE/FIN is ignored.
REQ-026 load_val=0 SHALL still run S0-S4; first CUR read returns 0 and S4 follows.
REQ-027 err SHALL clear only when a new start is accepted; cur_val holds until the next S3 read.
REQ-028 PSEL SHALL be 0 in IDLE, GAP and FIN; PENABLE only in ACCESS.

Reset
REQ-029 PRESET high at an edge SHALL force IDLE, step S0, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, busy=done=err=0, cur_val=0, poll and gap counters 0.
REQ-030 Reset mid-transfer SHALL drop PSEL in the cycle after the reset edge with no done pulse.

Configuration
REQ-031 With macro SEQ_TIMEOUT_EN defined, a poll counter SHALL count S3 reads; reaching MAX_POLLS reads with CUR!=0 sets err and goes to S4.
REQ-032 Without SEQ_TIMEOUT_EN, no poll counter SHALL exist and S3 polls indefinitely until CUR==0 or abort.

Verification
REQ-033 start, load_val=3, PREADY=1 -> writes MAX=3, CTRL=2, CTRL=1, CUR reads until 0, CTRL=0, one done pulse, cur_val=0, err=0.
REQ-034 PREADY held low 3 ACCESS cycles on S0 -> PSEL/PENABLE/PADDR=0x4/PWDATA stable 4 ACCESS cycles, sequence then continues.
REQ-035 PSLVERR=1 on S1 -> err=1, next transfer is write CTRL=0x0, done pulses; err clears on next start.
REQ-036 abort during GAP with load_val=100 -> next transfer CTRL=0x0 write, done pulses, cur_val holds last nonzero read.
REQ-037 SEQ_TIMEOUT_EN, MAX_POLLS=4, slave CUR stuck at 5 -> exactly 4 CUR reads, err=1, CTRL=0x0 write, done.
REQ-038 PRESET during S2 ACCESS -> all outputs 0 next cycle, no done; fresh start runs the full sequence.
